uart_frame_rx: RTL and testbench
================================

// Module: uart_frame_rx
// PURPOSE
//   Standalone UART receiver. It is the far end of the uart_tx serial line.
//   - Synchronises the asynchronous rx pin.
//   - Samples each bit at mid-bit and deserialises a DATA_WIDTH frame, LSB first.
//   - Checks the stop bit and, optionally, even parity.
//   - Presents the word with a one-cycle ready strobe to the bus-side consumer.
// PARAMETERS
//   CLOCKS_PER_PULSE  5208  clk cycles per bit; must be >= 4
//   DATA_WIDTH        8     data bits per frame; range 1..32
// PORTS
//   clk        in   1           single clock, rising edge
//   rst        in   1           asynchronous, active-high reset
//   rx         in   1           serial input; idle high; asynchronous to clk
//   data_out   out  DATA_WIDTH  last good word; held until the next good frame
//   ready      out  1           1-cycle pulse: data_out was updated this cycle
//   frame_err  out  1           1-cycle pulse: stop bit sampled low
//   parity_err out  1           1-cycle pulse, issued with ready, on parity mismatch
//   busy       out  1           high whenever the FSM is not in IDLE
// BEHAVIOUR
//   Reset (async, rst=1)
//     - data_out=0, ready=0, frame_err=0, parity_err=0, busy=0.
//     - Sync flops=1, state=IDLE, bit counter=0, clock counter=0.
//     - rst asserted mid-frame aborts immediately; the partial word is discarded.
//   Sync: 2-flop synchroniser on rx; the FSM sees only rx_s.
//   Clock counter: width $clog2(CLOCKS_PER_PULSE); cleared on every state entry.
//   FSM
//     IDLE : rx_s==0 -> START.
//     START: at count CLOCKS_PER_PULSE/2-1, sample rx_s.
//            1 -> IDLE (glitch; no error flagged). 0 -> DATA, bit index=0.
//     DATA : at count CLOCKS_PER_PULSE-1, shift rx_s in at the MSB (LSB-first line order).
//            After bit DATA_WIDTH-1 -> PARITY if UART_PARITY_EN is defined, else -> STOP.
//     PARITY: at count CLOCKS_PER_PULSE-1, latch the parity bit -> STOP.
//     STOP : at count CLOCKS_PER_PULSE-1, sample rx_s.
//            1 -> load data_out, pulse ready (+ parity_err if mismatch) -> IDLE.
//            0 -> pulse frame_err; data_out unchanged -> BREAK.
//     BREAK: wait for rx_s==1 (line break or framing loss), then -> IDLE.
//            No new frame can start while in BREAK.
//   Outputs
//     - ready, frame_err and parity_err are registered and never assert together,
//       except parity_err with ready.
//   Latency (rx falling edge to ready)
//     - 2 + CLOCKS_PER_PULSE/2 + (DATA_WIDTH+1[+1 parity])*CLOCKS_PER_PULSE + 1 cycles, +/-1.
//   Back-to-back frames
//     - The start bit is detected on the first IDLE cycle after STOP.
//     - A minimum one-bit stop is tolerated; there is no inter-frame gap requirement.
// CONFIGURATION
//   UART_PARITY_EN defined
//     - One even-parity bit is expected after the data bits.
//     - parity_err = ^{data,parity_bit}; it pulses with ready.
//     - The word is delivered even when parity fails.
//   UART_PARITY_EN undefined
//     - No parity bit; the PARITY state is absent.
//     - parity_err is tied to 0.
// TESTING (CLOCKS_PER_PULSE=16, DATA_WIDTH=8 unless noted)
//   1. Reset: hold rst=1 with rx toggling.
//      -> All outputs 0, busy=0. After release with rx=1 idle -> no ready.
//   2. Good frame: send 0xA5 (8N1).
//      -> Single ready pulse; data_out=0xA5.
//      -> ready appears within 2+8+9*16+1 cycles (+/-1) of the start edge.
//      -> frame_err=0.
//   3. Glitch: rx low for 4 cycles, then high.
//      -> busy pulses, returns to IDLE; no ready, no frame_err.
//   4. Framing error: send 0x3C with stop bit = 0, line held low 3 bits, then 0x81 sent.
//      -> frame_err pulse; data_out stays at its prior value.
//      -> Then ready with data_out=0x81.
//   5. Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap.
//      -> Three ready pulses, values in order.
//   6. With UART_PARITY_EN: send 0x07 with parity=0 (wrong).
//      -> ready + parity_err in the same cycle; data_out=0x07.
//      -> Resend with parity=1 -> ready, parity_err=0.

Source files
------------

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: UART receiver. It synchronises rx, samples each bit at mid-bit and checks the stop bit.
// Define UART_PARITY_EN to expect one even-parity bit after the data bits.
module uart_frame_rx #(
    parameter int unsigned CLOCKS_PER_PULSE = 5208,
    parameter int unsigned DATA_WIDTH       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  busy
);
    localparam int unsigned CW = $clog2(CLOCKS_PER_PULSE);
    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ready_q, ready_d;
    logic                  ferr_q, ferr_d;
`ifdef UART_PARITY_EN
    logic                  par_q, par_d;
    logic                  perr_q, perr_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
`ifdef UART_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        ready_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    // Line order is LSB first: each new bit enters at the MSB and shifts down.
                    shift_d = (shift_q >> 1) | (DATA_WIDTH'(rx_s_q) << (DATA_WIDTH - 1));
                    idx_d   = idx_q + BW'(1);
                    if (idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
`ifdef UART_PARITY_EN
                        perr_d  = ^{shift_q, par_q};
`endif
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_out  = data_q;
    assign ready     = ready_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);
`ifdef UART_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_rx.sv
// Testbench for uart_frame_rx: drives randomized serial frames and compares received words to a frame-level model.
// Build with UART_PARITY_EN defined to exercise the parity bit as well.
module tb_uart_frame_rx;
    localparam int unsigned CPP = 16;
    localparam int unsigned DW  = 8;
`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int unsigned LAT = 2 + CPP / 2 + (DW + 1 + (PAR_EN ? 1 : 0)) * CPP + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic [DW-1:0] data_out;
    logic          ready, frame_err, parity_err, busy;

    uart_frame_rx #(
        .CLOCKS_PER_PULSE(CPP),
        .DATA_WIDTH      (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .ready     (ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] d;
        logic          rdy;
        logic          fe;
        logic          pe;
        int unsigned   c;
    } ev_t;

    ev_t           evq[$];
    int unsigned   bad_combo = 0;
    bit            busy_seen = 1'b0;
    int            passed = 0;
    int            total  = 0;
    logic [DW-1:0] last_word = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (ready || frame_err || parity_err) begin
                ev_t e;
                e.d   = data_out;
                e.rdy = ready;
                e.fe  = frame_err;
                e.pe  = parity_err;
                e.c   = cyc;
                evq.push_back(e);
            end
            if ((ready && frame_err) || (frame_err && parity_err) || (parity_err && !ready))
                bad_combo++;
            if (busy) busy_seen = 1'b1;
        end
    end

    // Model: the even-parity bit makes the count of ones in {data, parity} even.
    function automatic logic good_par(input logic [DW-1:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    function automatic logic exp_perr(input logic [DW-1:0] d, input logic pbit);
        return PAR_EN && ((($countones(d) + int'(pbit)) % 2) != 0);
    endfunction

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPP) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic stop,
                              output int unsigned t0);
        t0 = cyc;
        send_bit(1'b0);
        for (int i = 0; i < int'(DW); i++) send_bit(d[i]);
        if (PAR_EN) send_bit(pbit);
        send_bit(stop);
    endtask

    task automatic test_reset();
        int unsigned t0;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rx = 1'($urandom);
            @(negedge clk);
            total++;
            if ({data_out, ready, frame_err, parity_err, busy} !== '0) begin
                $display("FAIL reset_outputs: got data=%0h rdy=%0b fe=%0b pe=%0b busy=%0b expected all 0",
                         data_out, ready, frame_err, parity_err, busy);
            end else passed++;
        end
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        evq.delete();
        repeat (3 * CPP) @(negedge clk);
        total++;
        if (evq.size() != 0 || busy !== 1'b0) begin
            $display("FAIL reset_idle: got events=%0d busy=%0b expected 0 and 0", evq.size(), busy);
        end else passed++;

        // Abort a frame part-way through with an asynchronous reset.
        t0 = cyc;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || data_out !== '0) begin
            $display("FAIL reset_abort: got busy=%0b data=%0h expected 0 and 0", busy, data_out);
        end else passed++;
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12 * CPP) @(negedge clk);
        total++;
        if (evq.size() != 0 || data_out !== '0) begin
            $display("FAIL reset_abort_discard: got events=%0d data=%0h expected 0 and 0", evq.size(), data_out);
        end else passed++;
    endtask

    task automatic test_good_frame();
        logic [DW-1:0] w[$];
        int unsigned   t0;
        w.push_back(8'hA5);
        for (int i = 0; i < 4; i++) w.push_back(DW'($urandom));
        foreach (w[i]) begin
            evq.delete();
            send_frame(w[i], good_par(w[i]), 1'b1, t0);
            repeat (CPP) @(negedge clk);
            total++;
            if (evq.size() != 1) begin
                $display("FAIL good_count: word %0h got %0d events expected 1", w[i], evq.size());
            end else begin
                ev_t e;
                int  lat;
                e   = evq.pop_front();
                lat = int'(e.c) - int'(t0);
                if (e.rdy !== 1'b1 || e.d !== w[i] || e.fe !== 1'b0 || e.pe !== 1'b0) begin
                    $display("FAIL good_word: got rdy=%0b data=%0h fe=%0b pe=%0b expected 1 %0h 0 0",
                             e.rdy, e.d, e.fe, e.pe, w[i]);
                end else passed++;
                total++;
                if (lat < int'(LAT) - 1 || lat > int'(LAT) + 1) begin
                    $display("FAIL good_latency: got %0d cycles expected %0d +/-1", lat, LAT);
                end else passed++;
                last_word = w[i];
            end
        end
        total++;
        if (data_out !== last_word || busy !== 1'b0) begin
            $display("FAIL good_hold: got data=%0h busy=%0b expected %0h 0", data_out, busy, last_word);
        end else passed++;
    endtask

    task automatic test_glitch();
        int unsigned len[2];
        len[0] = 4;
        len[1] = $urandom_range(1, 5);
        for (int g = 0; g < 2; g++) begin
            evq.delete();
            busy_seen = 1'b0;
            rx = 1'b0;
            repeat (len[g]) @(negedge clk);
            rx = 1'b1;
            repeat (2 * CPP) @(negedge clk);
            total++;
            if (busy_seen !== 1'b1 || busy !== 1'b0 || evq.size() != 0 || data_out !== last_word) begin
                $display("FAIL glitch_len%0d: got busy_seen=%0b busy=%0b events=%0d data=%0h expected 1 0 0 %0h",
                         len[g], busy_seen, busy, evq.size(), data_out, last_word);
            end else passed++;
        end
    endtask

    task automatic test_frame_err();
        int unsigned t0;
        evq.delete();
        send_frame(8'h3C, good_par(8'h3C), 1'b0, t0);
        repeat (3) send_bit(1'b0);
        total++;
        if (busy !== 1'b1) begin
            $display("FAIL ferr_break_busy: got busy=%0b expected 1", busy);
        end else passed++;
        send_bit(1'b1);
        total++;
        if (evq.size() != 1) begin
            $display("FAIL ferr_count: got %0d events expected 1", evq.size());
        end else begin
            ev_t e;
            e = evq.pop_front();
            if (e.fe !== 1'b1 || e.rdy !== 1'b0 || e.pe !== 1'b0 || e.d !== last_word) begin
                $display("FAIL ferr_pulse: got fe=%0b rdy=%0b pe=%0b data=%0h expected 1 0 0 %0h",
                         e.fe, e.rdy, e.pe, e.d, last_word);
            end else passed++;
        end
        send_frame(8'h81, good_par(8'h81), 1'b1, t0);
        repeat (CPP) @(negedge clk);
        total++;
        if (evq.size() != 1) begin
            $display("FAIL ferr_recover_count: got %0d events expected 1", evq.size());
        end else begin
            ev_t e;
            e = evq.pop_front();
            if (e.rdy !== 1'b1 || e.d !== 8'h81 || e.fe !== 1'b0) begin
                $display("FAIL ferr_recover: got rdy=%0b data=%0h fe=%0b expected 1 81 0", e.rdy, e.d, e.fe);
            end else passed++;
            last_word = 8'h81;
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w[$];
        int unsigned   t0;
        w = '{8'h00, 8'hFF, 8'h55};
        for (int i = 0; i < 3; i++) w.push_back(DW'($urandom));
        evq.delete();
        foreach (w[i]) send_frame(w[i], good_par(w[i]), 1'b1, t0);
        repeat (2 * CPP) @(negedge clk);
        total++;
        if (evq.size() != w.size()) begin
            $display("FAIL b2b_count: got %0d events expected %0d", evq.size(), w.size());
        end else passed++;
        foreach (w[i]) begin
            if (evq.size() != 0) begin
                ev_t e;
                e = evq.pop_front();
                total++;
                if (e.rdy !== 1'b1 || e.d !== w[i] || e.fe !== 1'b0) begin
                    $display("FAIL b2b_word%0d: got rdy=%0b data=%0h fe=%0b expected 1 %0h 0",
                             i, e.rdy, e.d, e.fe, w[i]);
                end else passed++;
                last_word = w[i];
            end
        end
    endtask

    task automatic test_parity();
        logic [DW-1:0] d[$];
        logic          p[$];
        int unsigned   t0;
        d = '{8'h07, 8'h07};
        p = '{1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            d.push_back(DW'($urandom));
            p.push_back(1'($urandom));
        end
        foreach (d[i]) begin
            evq.delete();
            send_frame(d[i], p[i], 1'b1, t0);
            repeat (CPP) @(negedge clk);
            total++;
            if (evq.size() != 1) begin
                $display("FAIL parity_count: word %0h got %0d events expected 1", d[i], evq.size());
            end else begin
                ev_t e;
                e = evq.pop_front();
                if (e.rdy !== 1'b1 || e.d !== d[i] || e.pe !== exp_perr(d[i], p[i]) || e.fe !== 1'b0) begin
                    $display("FAIL parity_word: got rdy=%0b data=%0h pe=%0b fe=%0b expected 1 %0h %0b 0",
                             e.rdy, e.d, e.pe, e.fe, d[i], exp_perr(d[i], p[i]));
                end else passed++;
                last_word = d[i];
            end
        end
    endtask

    task automatic test_exclusive();
        total++;
        if (bad_combo != 0) begin
            $display("FAIL output_exclusive: got %0d illegal pulse combinations expected 0", bad_combo);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_err();
        test_back_to_back();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_exclusive();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
